// File: rtl/wisc_wb_arbiter.sv
// Register-file write-back arbiter between the pipeline WB stage and a multi-cycle unit.
// Optional protocol checker on err is built only when WISC_WB_ARB_ERR_EN is defined.
module wisc_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_valid,
  input  logic [2:0]  p_reg,
  input  logic [15:0] p_data,
  input  logic        halt_in,
  input  logic        mc_valid,
  input  logic [2:0]  mc_reg,
  input  logic [15:0] mc_data,
  input  logic        mc_busy,
  output logic        mc_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        halt_out,
  output logic        err
);

  // Handshake: a write transfers on a cycle where its valid is high and it is
  // granted (p: p_valid & ~pipe_stall, mc: mc_valid & mc_ready); the requester
  // must hold its payload unchanged until then.
  typedef enum logic [1:0] {RUN, STARVE, DRAIN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        p_grant, mc_hs, halt_acc;

  always_comb begin
    pipe_stall = 1'b0;
    mc_ready   = 1'b0;
    p_grant    = 1'b0;
    halt_acc   = 1'b0;
    case (state_q)
      RUN: begin
        p_grant  = p_valid;
        mc_ready = mc_valid & ~p_valid;
        halt_acc = halt_in;
      end
      STARVE, DRAIN: begin
        pipe_stall = 1'b1;
        mc_ready   = 1'b1;
      end
      HALTED: pipe_stall = 1'b1;
      default: ;
    endcase
  end

  assign mc_hs = mc_valid & mc_ready;

  always_comb begin
    wait_d = wait_q;
    if (!mc_valid || mc_hs)
      wait_d = 3'd0;
    else if (wait_q != 3'd7)
      wait_d = wait_q + 3'd1;
  end

  // The threshold is tested on the value the counter takes at this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_acc)
          state_d = DRAIN;
        else if (wait_d == 3'(STARVE_LIMIT))
          state_d = STARVE;
      end
      STARVE: state_d = RUN;
      DRAIN: begin
        if (!mc_busy && !mc_valid)
          state_d = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= 3'd0;
      rf_wdata <= 16'd0;
    end else if (p_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= p_reg;
      rf_wdata <= p_data;
    end else if (mc_hs) begin
      rf_we    <= 1'b1;
      rf_waddr <= mc_reg;
      rf_wdata <= mc_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign halt_out = (state_q == HALTED);

`ifdef WISC_WB_ARB_ERR_EN
  logic        waiting_q;
  logic [2:0]  mc_reg_q;
  logic [15:0] mc_data_q;
  logic        err_q;
  logic        err_set;

  // Flags a withdrawn or mutated mc request, or a pipeline write after halt.
  always_comb begin
    err_set = (waiting_q & ~mc_valid)
            | (waiting_q & mc_valid & ((mc_reg != mc_reg_q) | (mc_data != mc_data_q)))
            | (p_valid & (state_q == HALTED));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting_q <= 1'b0;
      mc_reg_q  <= 3'd0;
      mc_data_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      waiting_q <= mc_valid & ~mc_ready;
      mc_reg_q  <= mc_reg;
      mc_data_q <= mc_data;
      if (err_set)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wisc_wb_arbiter.sv
// Bench for wisc_wb_arbiter: RUN-mode vector table, then hand-written starvation,
// halt/drain, async-reset and error-flag sequences checked against a write scoreboard.
module tb_wisc_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_valid = 1'b0;
  logic [2:0]  p_reg = '0;
  logic [15:0] p_data = '0;
  logic        halt_in = 1'b0;
  logic        mc_valid = 1'b0;
  logic [2:0]  mc_reg = '0;
  logic [15:0] mc_data = '0;
  logic        mc_busy = 1'b0;
  logic        mc_ready, pipe_stall, rf_we, halt_out, err;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;

  always #5 clk = ~clk;

  wisc_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_reg(p_reg), .p_data(p_data), .halt_in(halt_in),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_busy(mc_busy),
    .mc_ready(mc_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .halt_out(halt_out), .err(err)
  );

`ifdef WISC_WB_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [19:0] exp_q[$];
  logic [2:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic reset_sb();
    exp_q.delete();
    last_addr = '0;
    last_data = '0;
  endtask

  // Expected register-file outputs after the coming edge; address/data hold when no write.
  task automatic push_wr(input logic we, input logic [2:0] addr, input logic [15:0] data);
    if (we) begin
      last_addr = addr;
      last_data = data;
    end
    exp_q.push_back({we, last_addr, last_data});
  endtask

  task automatic tick(input string name);
    logic [19:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_sb: got empty queue expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_we"},    32'(rf_we),    32'(e[19]));
      chk({name, "_waddr"}, 32'(rf_waddr), 32'(e[18:16]));
      chk({name, "_wdata"}, 32'(rf_wdata), 32'(e[15:0]));
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are already applied; check grant outputs, record the expected write, clock.
  task automatic cyc(input string name, input logic e_ready, input logic e_stall,
                     input logic e_we, input logic [2:0] e_addr, input logic [15:0] e_data);
    #1;
    chk({name, "_mc_ready"},   32'(mc_ready),   32'(e_ready));
    chk({name, "_pipe_stall"}, 32'(pipe_stall), 32'(e_stall));
    push_wr(e_we, e_addr, e_data);
    tick(name);
  endtask

  task automatic clear_inputs();
    p_valid = 0; p_reg = 0; p_data = 0; halt_in = 0;
    mc_valid = 0; mc_reg = 0; mc_data = 0; mc_busy = 0;
  endtask

  task automatic do_reset(input string name);
    rst_n = 0;
    clear_inputs();
    #2;
    chk({name, "_rf_we"},    32'(rf_we),    32'd0);
    chk({name, "_halt_out"}, 32'(halt_out), 32'd0);
    chk({name, "_stall"},    32'(pipe_stall), 32'd0);
    @(negedge clk);
    rst_n = 1;
    reset_sb();
  endtask

  typedef struct {
    logic        p_valid;
    logic [2:0]  p_reg;
    logic [15:0] p_data;
    logic        mc_valid;
    logic [2:0]  mc_reg;
    logic [15:0] mc_data;
    logic        e_ready;
    logic        e_we;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;

    vecs[0] = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h1234};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b1, 3'd5, 16'hBEEF};
    vecs[3] = '{1'b1, 3'd1, 16'h1111, 1'b1, 3'd6, 16'h6666, 1'b0, 1'b1, 3'd1, 16'h1111};
    vecs[4] = '{1'b1, 3'd2, 16'h2222, 1'b1, 3'd6, 16'h6666, 1'b0, 1'b1, 3'd2, 16'h2222};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h6666, 1'b1, 1'b1, 3'd6, 16'h6666};
    vecs[6] = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd7, 16'hFFFF};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd0, 16'h0000};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000};

    // Reset state; combinational outputs follow RUN rules while reset is held.
    mc_valid = 1;
    #3;
    chk("rst_rf_we",    32'(rf_we),    32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_halt_out", 32'(halt_out), 32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_stall",    32'(pipe_stall), 32'd0);
    chk("rst_mc_ready", 32'(mc_ready), 32'd1);
    @(negedge clk);
    mc_valid = 0;
    rst_n = 1;
    reset_sb();

    // RUN-mode vector table
    for (int i = 0; i < 9; i++) begin
      p_valid = vecs[i].p_valid; p_reg = vecs[i].p_reg; p_data = vecs[i].p_data;
      mc_valid = vecs[i].mc_valid; mc_reg = vecs[i].mc_reg; mc_data = vecs[i].mc_data;
      cyc($sformatf("vec%0d", i), vecs[i].e_ready, 1'b0,
          vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data);
    end
    chk("table_err", 32'(err), 32'd0);

    // Starvation: mc waits 4 cycles, then one stalled cycle grants it.
    p_valid = 1; p_reg = 3'd1; mc_valid = 1; mc_reg = 3'd5; mc_data = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      p_data = d;
      cyc("conf_wait", 1'b0, 1'b0, 1'b1, 3'd1, d);
    end
    d = 16'($urandom_range(0, 16'hFFFF));
    p_data = d;
    cyc("conf_starve", 1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF);
    mc_valid = 0;
    cyc("conf_back", 1'b0, 1'b0, 1'b1, 3'd1, d);
    p_valid = 0;
    cyc("conf_idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);

    // Halt accepted on the threshold cycle goes to DRAIN, not STARVE.
    p_valid = 1; p_reg = 3'd2; mc_valid = 1; mc_reg = 3'd6; mc_data = 16'hCAFE;
    for (int i = 0; i < 4; i++) begin
      d = 16'h2000 + 16'(i);
      p_data = d;
      if (i == 3) halt_in = 1;
      cyc("thr_wait", 1'b0, 1'b0, 1'b1, 3'd2, d);
    end
    p_data = 16'h2FFF;
    cyc("thr_drain", 1'b1, 1'b1, 1'b1, 3'd6, 16'hCAFE);
    chk("thr_halt_out0", 32'(halt_out), 32'd0);
    p_valid = 0; mc_valid = 0;
    cyc("thr_drain2", 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
    chk("thr_halt_out1", 32'(halt_out), 32'd1);
    halt_in = 0; mc_valid = 1; mc_reg = 3'd7; mc_data = 16'h7777;
    for (int i = 0; i < 2; i++) begin
      cyc("halted", 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
      chk("halted_halt_out", 32'(halt_out), 32'd1);
    end
    chk("halted_err", 32'(err), 32'd0);
    do_reset("rst_halted");

    // Halt while mc unit is busy; retire its write, then halt.
    halt_in = 1; mc_busy = 1;
    cyc("drn_acc", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    for (int i = 0; i < 2; i++) begin
      cyc("drn_busy", 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
      chk("drn_busy_halt_out", 32'(halt_out), 32'd0);
    end
    mc_busy = 0; mc_valid = 1; mc_reg = 3'd2; mc_data = 16'h00FF;
    cyc("drn_mc", 1'b1, 1'b1, 1'b1, 3'd2, 16'h00FF);
    chk("drn_mc_halt_out", 32'(halt_out), 32'd0);
    mc_valid = 0;
    cyc("drn_last", 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
    chk("drn_halt_out", 32'(halt_out), 32'd1);
    halt_in = 0;
    cyc("drn_hold", 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    chk("drn_hold_halt_out", 32'(halt_out), 32'd1);
    do_reset("rst_drain");

    // Asynchronous reset while in STARVE discards the pending grant.
    p_valid = 1; p_reg = 3'd4; mc_valid = 1; mc_reg = 3'd3; mc_data = 16'h3333;
    for (int i = 0; i < 4; i++) begin
      d = 16'h4000 + 16'(i);
      p_data = d;
      cyc("ar_wait", 1'b0, 1'b0, 1'b1, 3'd4, d);
    end
    #1;
    chk("ar_starve_stall", 32'(pipe_stall), 32'd1);
    chk("ar_starve_ready", 32'(mc_ready),   32'd1);
    #1;
    rst_n = 0;
    #1;
    chk("ar_rf_we",    32'(rf_we),      32'd0);
    chk("ar_halt_out", 32'(halt_out),   32'd0);
    chk("ar_err",      32'(err),        32'd0);
    chk("ar_stall",    32'(pipe_stall), 32'd0);
    chk("ar_ready",    32'(mc_ready),   32'd0);
    @(negedge clk);
    rst_n = 1;
    reset_sb();
    cyc("ar_post", 1'b0, 1'b0, 1'b1, 3'd4, d);
    p_valid = 0;
    cyc("ar_post_mc", 1'b1, 1'b0, 1'b1, 3'd3, 16'h3333);
    mc_valid = 0;
    cyc("ar_idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);

    // mc request withdrawn while waiting.
    p_valid = 1; p_reg = 3'd1; p_data = 16'h5151;
    mc_valid = 1; mc_reg = 3'd4; mc_data = 16'h4444;
    cyc("err_wait", 1'b0, 1'b0, 1'b1, 3'd1, 16'h5151);
    p_valid = 0; mc_valid = 0;
    chk("err_before", 32'(err), 32'd0);
    cyc("err_drop", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("err_set", 32'(err), 32'(ERR_EXP));
    cyc("err_idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("err_held", 32'(err), 32'(ERR_EXP));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
